// File: rtl/demux4_buf.sv
// -----------------------------------------------------------------------------
// demux4_buf
//   1-to-4 registered demultiplexer. A single producer presents a WIDTH-bit
//   word on d with a valid/ready handshake. Each accepted word is steered
//   into the one-entry holding register of the target channel. Each of the
//   four consumers drains its own channel through q_valid[n] / q_ready[n].
//
//   Ports:
//     clk       rising-edge clock
//     reset     asynchronous, active-high reset
//     d         input data word
//     s         destination channel select (addressed mode only)
//     in_valid  producer has a word on d
//     in_ready  block can accept the word this cycle (combinational)
//     q0..q3    channel holding-register contents
//     q_valid   bit n: channel n holds a valid word
//     q_ready   bit n: consumer n takes its word this cycle
//     sel_cur   channel currently targeted by the input
//     count     number of words accepted since reset (wraps)
//
//   Optional feature macro: DEMUX_AUTOSEL_EN
//     Defined   : s is ignored. An internal round-robin pointer picks the
//                 target channel and advances only on accept.
//     Undefined : sel_cur follows s combinationally. No pointer register.
// -----------------------------------------------------------------------------
module demux4_buf #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [3:0]       q_valid,
    input  logic [3:0]       q_ready,
    output logic [1:0]       sel_cur,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_t;

    chan_state_t [3:0]            state_r;
    logic        [3:0][WIDTH-1:0] data_r;
    logic        [CNT_W-1:0]      count_r;

    logic       [1:0] sel_s;
    logic       [3:0] valid_s;
    logic       [3:0] load_s;
    logic             ready_s;
    logic             accept_s;

`ifdef DEMUX_AUTOSEL_EN
    logic [1:0] ptr_r;

    // Round-robin pointer: moves on only when a word is actually taken, so a
    // stall on a full channel keeps the strict 0,1,2,3 ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= 2'd0;
        end else if (accept_s) begin
            ptr_r <= ptr_r + 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign sel_s = ptr_r;
`else
    assign sel_s = s;
`endif

    // Channel occupancy, target-channel readiness and one-hot load enables.
    always_comb begin
        valid_s  = 4'b0000;
        load_s   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            valid_s[i] = (state_r[i] == ST_FULL);
        end
        // Only the targeted channel gates the producer; a slot frees up in
        // the same cycle its consumer drains it.
        ready_s  = ~valid_s[sel_s] | q_ready[sel_s];
        accept_s = in_valid & ready_s;
        if (accept_s) begin
            load_s[sel_s] = 1'b1;
        end else begin
            load_s = 4'b0000;
        end
    end

    // Per-channel EMPTY/FULL state machine and holding registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= {4{ST_EMPTY}};
            data_r  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (state_r[i])
                    ST_EMPTY: begin
                        if (load_s[i]) begin
                            state_r[i] <= ST_FULL;
                        end else begin
                            state_r[i] <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        // A load wins over a drain so back-to-back words
                        // keep the channel full at one word per cycle.
                        if (load_s[i]) begin
                            state_r[i] <= ST_FULL;
                        end else if (q_ready[i]) begin
                            state_r[i] <= ST_EMPTY;
                        end else begin
                            state_r[i] <= ST_FULL;
                        end
                    end
                    default: begin
                        state_r[i] <= ST_EMPTY;
                    end
                endcase
                // Data only changes on a load; a drain leaves the old word.
                if (load_s[i]) begin
                    data_r[i] <= d;
                end else begin
                    data_r[i] <= data_r[i];
                end
            end
        end
    end

    // Accepted-word counter, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (accept_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign in_ready = ready_s;
    assign q_valid  = valid_s;
    assign sel_cur  = sel_s;
    assign count    = count_r;
    assign q0       = data_r[0];
    assign q1       = data_r[1];
    assign q2       = data_r[2];
    assign q3       = data_r[3];

endmodule
